// File: rtl/pwm_fade_sequencer_if.sv
// Request/status bundle between the fade controller and its requester / PWM.
// The master drives the fade request; the slave drives PWM settings and status.
interface pwm_fade_sequencer_if;
  logic        start;
  logic        stop;
  logic [15:0] duty_min;
  logic [15:0] duty_max;
  logic [15:0] hold_ticks;
  logic [15:0] duty_cycle;
  logic [15:0] period;
  logic        busy;
  logic [1:0]  phase;
  logic        cycle_done;
  logic        cfg_err;

  modport master (
    output start, stop, duty_min, duty_max, hold_ticks,
    input  duty_cycle, period, busy, phase, cycle_done, cfg_err
  );

  modport slave (
    input  start, stop, duty_min, duty_max, hold_ticks,
    output duty_cycle, period, busy, phase, cycle_done, cfg_err
  );
endinterface

// File: rtl/pwm_fade_sequencer.sv
// Rise/hold/fall duty-cycle sequencer feeding the shared PWM generator.
// Define PWM_FADE_LOOP_EN to repeat the fade continuously until stop.
module pwm_fade_sequencer #(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned PWM_FREQ = 500,
  parameter int unsigned STEP_DIV = 256,
  parameter int unsigned STEP     = 1
) (
  input logic                 clk,
  input logic                 rst,
  pwm_fade_sequencer_if.slave bus
);

  localparam logic [15:0] PERIOD = 16'(CLK_FREQ / PWM_FREQ);
  localparam logic [15:0] STEP16 = 16'(STEP);
  localparam logic [16:0] STEP17 = 17'(STEP);
  localparam int unsigned TW     = $clog2(STEP_DIV);
  localparam logic [TW-1:0] TMAX = TW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    HOLD = 2'd2,
    FALL = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   duty, duty_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [15:0]   hold_cnt, hold_cnt_nxt;
  logic [15:0]   lo, lo_nxt;
  logic [15:0]   hi, hi_nxt;
  logic [15:0]   hold, hold_nxt;
  logic          cycle_done_q, cycle_done_nxt;
  logic          cfg_err_q, cfg_err_nxt;
  logic          tick;
  logic [15:0]   hi_in;

  assign tick  = (state != IDLE) && (timer == TMAX);
  assign hi_in = (bus.duty_max > PERIOD) ? PERIOD : bus.duty_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      duty         <= '0;
      timer        <= '0;
      hold_cnt     <= '0;
      lo           <= '0;
      hi           <= '0;
      hold         <= '0;
      cycle_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state        <= state_nxt;
      duty         <= duty_nxt;
      timer        <= timer_nxt;
      hold_cnt     <= hold_cnt_nxt;
      lo           <= lo_nxt;
      hi           <= hi_nxt;
      hold         <= hold_nxt;
      cycle_done_q <= cycle_done_nxt;
      cfg_err_q    <= cfg_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    duty_nxt       = duty;
    lo_nxt         = lo;
    hi_nxt         = hi;
    hold_nxt       = hold;
    hold_cnt_nxt   = hold_cnt;
    timer_nxt      = timer;
    cycle_done_nxt = 1'b0;
    cfg_err_nxt    = 1'b0;

    if (bus.stop) begin
      duty_nxt  = '0;
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            lo_nxt   = bus.duty_min;
            hi_nxt   = hi_in;
            hold_nxt = bus.hold_ticks;
            if (hi_in <= bus.duty_min) begin
              cfg_err_nxt = 1'b1;
            end else begin
              duty_nxt  = bus.duty_min;
              state_nxt = RISE;
            end
          end
        end
        RISE: begin
          if (tick) begin
            if (({1'b0, duty} + STEP17) >= {1'b0, hi}) begin
              duty_nxt  = hi;
              state_nxt = HOLD;
            end else begin
              duty_nxt = duty + STEP16;
            end
          end
        end
        HOLD: begin
          if (hold == '0) begin
            state_nxt = FALL;
          end else if (tick) begin
            if (hold_cnt == hold - 16'd1) state_nxt = FALL;
            else                          hold_cnt_nxt = hold_cnt + 16'd1;
          end
        end
        FALL: begin
          if (tick) begin
            if ({1'b0, duty} <= ({1'b0, lo} + STEP17)) begin
              duty_nxt       = lo;
              cycle_done_nxt = 1'b1;
`ifdef PWM_FADE_LOOP_EN
              state_nxt = RISE;
`else
              state_nxt = IDLE;
`endif
            end else begin
              duty_nxt = duty - STEP16;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Every state entry (including FALL->RISE in loop mode) restarts step timing.
    if (state_nxt != state) begin
      timer_nxt    = '0;
      hold_cnt_nxt = '0;
    end else if (state != IDLE) begin
      timer_nxt = tick ? '0 : timer + TW'(1);
    end
  end

  assign bus.duty_cycle = duty;
  assign bus.period     = PERIOD;
  assign bus.busy       = (state != IDLE);
  assign bus.phase      = state;
  assign bus.cycle_done = cycle_done_q;
  assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench: directed scenarios plus randomized fades against a
// trajectory model built from the fade rules (rise/hold/fall step arithmetic).
module tb_pwm_fade_sequencer;
  localparam int SD  = 4;
  localparam int ST  = 10;
  localparam int PER = 50000;
`ifdef PWM_FADE_LOOP_EN
  localparam int END_PHASE = 1;
`else
  localparam int END_PHASE = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_fade_sequencer_if bus();

  pwm_fade_sequencer #(
    .CLK_FREQ(25_000_000),
    .PWM_FREQ(500),
    .STEP_DIV(SD),
    .STEP(ST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_d[$];
  int exp_p[$];
  int exp_c[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int p, input int c, input int n);
    repeat (n) begin
      exp_d.push_back(d);
      exp_p.push_back(p);
      exp_c.push_back(c);
    end
  endtask

  // Expected per-cycle observation starting right after the accepting edge.
  task automatic build_model(input int lo, input int hi, input int hold);
    int d;
    exp_d.delete();
    exp_p.delete();
    exp_c.delete();
    d = lo;
    push(d, 1, 0, SD);
    while (d + ST < hi) begin
      d += ST;
      push(d, 1, 0, SD);
    end
    d = hi;
    push(d, 2, 0, (hold == 0) ? 1 : hold * SD);
    push(d, 3, 0, SD);
    while (d > lo + ST) begin
      d -= ST;
      push(d, 3, 0, SD);
    end
    push(lo, END_PHASE, 1, 1);
  endtask

  task automatic run_fade(input int mn, input int mx, input int hold, input bit disturb);
    int hi;
    int k_dist;
    bus.duty_min   = 16'(mn);
    bus.duty_max   = 16'(mx);
    bus.hold_ticks = 16'(hold);
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    hi = (mx > PER) ? PER : mx;
    if (hi <= mn) begin
      check("cfg_err_pulse", bus.cfg_err, 1);
      check("reject_busy", bus.busy, 0);
      check("reject_phase", bus.phase, 0);
      step();
      check("cfg_err_clear", bus.cfg_err, 0);
      check("reject_busy2", bus.busy, 0);
      return;
    end
    build_model(mn, hi, hold);
    k_dist = disturb ? int'($urandom_range(1, 6)) : -1;
    for (int k = 0; k < exp_d.size(); k++) begin
      if (k > 0) step();
      check("duty", bus.duty_cycle, exp_d[k]);
      check("phase", bus.phase, exp_p[k]);
      check("busy", bus.busy, (exp_p[k] != 0) ? 1 : 0);
      check("cycle_done", bus.cycle_done, exp_c[k]);
      bus.start = (k == k_dist);
      if (k == k_dist) begin
        bus.duty_min   = 16'($urandom_range(0, 100));
        bus.duty_max   = 16'($urandom_range(200, 400));
        bus.hold_ticks = 16'($urandom_range(0, 5));
      end
    end
    bus.start = 1'b0;
`ifdef PWM_FADE_LOOP_EN
    repeat (3) begin
      step();
      check("loop_busy", bus.busy, 1);
      check("loop_phase", bus.phase, 1);
      check("loop_duty", bus.duty_cycle, mn);
      check("loop_cd_low", bus.cycle_done, 0);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("loop_stop_duty", bus.duty_cycle, 0);
    check("loop_stop_busy", bus.busy, 0);
    check("loop_stop_cd", bus.cycle_done, 0);
`else
    step();
    check("end_cd_low", bus.cycle_done, 0);
    check("end_busy", bus.busy, 0);
    check("end_phase", bus.phase, 0);
    check("end_duty", bus.duty_cycle, mn);
`endif
  endtask

  initial begin
    int lo;
    int mx;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.duty_min   = '0;
    bus.duty_max   = '0;
    bus.hold_ticks = '0;
    repeat (2) step();
    check("rst_duty", bus.duty_cycle, 0);
    check("rst_phase", bus.phase, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cd", bus.cycle_done, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("period", bus.period, PER);
    rst = 1'b0;
    step();

    // Asynchronous reset in the middle of RISE.
    bus.duty_min = 16'd0; bus.duty_max = 16'd30; bus.hold_ticks = 16'd2;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    check("pre_rst_duty", bus.duty_cycle, 10);
    #3 rst = 1'b1;
    #1;
    check("async_rst_duty", bus.duty_cycle, 0);
    check("async_rst_phase", bus.phase, 0);
    check("async_rst_busy", bus.busy, 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_busy", bus.busy, 0);

    run_fade(0, 30, 2, 1'b0);
    run_fade(5, 23, 1, 1'b0);
    run_fade(49975, 60000, 0, 1'b0);
    run_fade(40, 40, 0, 1'b0);

    // start and stop together in IDLE: stop wins.
    bus.duty_min = 16'd0; bus.duty_max = 16'd30;
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    check("start_stop_busy", bus.busy, 0);
    check("start_stop_cfg_err", bus.cfg_err, 0);
    step();
    check("start_stop_busy2", bus.busy, 0);

    // stop during HOLD.
    bus.duty_min = 16'd0; bus.duty_max = 16'd30; bus.hold_ticks = 16'd2;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (13) step();
    check("in_hold_phase", bus.phase, 2);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("stop_duty", bus.duty_cycle, 0);
    check("stop_busy", bus.busy, 0);
    check("stop_phase", bus.phase, 0);
    check("stop_cd", bus.cycle_done, 0);
    step();
    check("stop_cd2", bus.cycle_done, 0);
    check("stop_busy2", bus.busy, 0);

    run_fade(0, 30, 1, 1'b1);
    run_fade(0, 20, 0, 1'b0);

    repeat (12) begin
      lo = int'($urandom_range(0, 50050));
      if ($urandom_range(0, 3) == 0) mx = lo - int'($urandom_range(0, lo));
      else                           mx = lo + int'($urandom_range(0, 90));
      run_fade(lo, mx, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
